prio_scan_enc: RTL and testbench

- Sequential 12-to-4 priority encoder; the inverse of our 4-to-12 binary decoder.
- Captures a 12-bit request vector and emits the codes of all set bits, one per handshake, highest priority first.
- Code mapping is identical to the decoder: bit k of the request maps to code k+1 (bit 11 -> 12, bit 0 -> 1). Code 0 means "none".
- Sits between request-collection logic and any consumer that drives the decoder, so the decoder(code) output reproduces each pending request bit in turn.

---
 rtl/prio_scan_enc_if.sv | 37 +++
 rtl/prio_scan_enc.sv | 99 +++++++++
 tb/tb_prio_scan_enc.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prio_scan_enc_if.sv
// Request/code handshake bundle for the sequential priority scan encoder.
// master = request producer and code consumer, slave = the encoder.
interface prio_scan_enc_if #(
  parameter int REQ_W  = 12,
  parameter int CODE_W = 4
);
  logic              load;
  logic [REQ_W-1:0]  req;
  logic              busy;
  logic              code_valid;
  logic              code_ready;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] count;
  logic              done;

  modport master (
    output load,
    output req,
    output code_ready,
    input  busy,
    input  code_valid,
    input  code,
    input  count,
    input  done
  );

  modport slave (
    input  load,
    input  req,
    input  code_ready,
    output busy,
    output code_valid,
    output code,
    output count,
    output done
  );
endinterface

// File: rtl/prio_scan_enc.sv
// Sequential priority encoder: emits code k+1 for each set req bit, one per handshake.
// PRIO_SCAN_ENC_LSB_FIRST_EN selects lowest-bit-first order (default highest first).
module prio_scan_enc #(
  parameter int REQ_W  = 12,
  parameter int CODE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  prio_scan_enc_if.slave   bus
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t            state;
  logic [REQ_W-1:0]  pending;
  logic              done_q;

  logic [CODE_W-1:0] sel_code;
  logic [REQ_W-1:0]  sel_bit;
  logic [REQ_W-1:0]  next_pending;
  logic [CODE_W-1:0] pop;
  logic              hs;

  // Last match in the loop wins, so loop direction sets priority.
  always_comb begin
    sel_code = '0;
    sel_bit  = '0;
`ifdef PRIO_SCAN_ENC_LSB_FIRST_EN
    for (int i = REQ_W - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_code = CODE_W'(i + 1);
        sel_bit  = REQ_W'(1) << i;
      end
    end
`else
    for (int i = 0; i < REQ_W; i++) begin
      if (pending[i]) begin
        sel_code = CODE_W'(i + 1);
        sel_bit  = REQ_W'(1) << i;
      end
    end
`endif
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < REQ_W; i++) begin
      pop = pop + CODE_W'(pending[i]);
    end
  end

  assign next_pending = pending & ~sel_bit;
  assign hs           = (state == SCAN) && bus.code_ready;

  assign bus.busy       = (state == SCAN);
  assign bus.code_valid = (state == SCAN);
  assign bus.code       = (state == SCAN) ? sel_code : '0;
  assign bus.count      = pop;
  assign bus.done       = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.load) begin
            if (bus.req != '0) begin
              pending <= bus.req;
              state   <= SCAN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (hs) begin
            pending <= next_pending;
            if (next_pending == '0) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_scan_enc.sv
// Directed bench for prio_scan_enc; build with +define+PRIO_SCAN_ENC_LSB_FIRST_EN
// to exercise the lowest-bit-first scan order.
module tb_prio_scan_enc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  prio_scan_enc_if #(.REQ_W(12), .CODE_W(4)) bus ();

  prio_scan_enc #(.REQ_W(12), .CODE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {busy, code_valid, code, count, done}
  function automatic logic [10:0] snap();
    return {bus.busy, bus.code_valid, bus.code, bus.count, bus.done};
  endfunction

  function automatic logic [10:0] ex(input logic b, input logic v,
                                     input logic [3:0] c, input logic [3:0] n,
                                     input logic d);
    return {b, v, c, n, d};
  endfunction

  task automatic test_reset();
    logic [10:0] o;
    bus.load = 1'b0;
    bus.req = '0;
    bus.code_ready = 1'b0;
    #2;
    o = snap();
    total++;
    if (o !== '0) begin
      $display("FAIL reset_init got=%h exp=%h", o, 11'h0);
      bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    // load a full vector, drain two codes, then reset mid-scan
    bus.load = 1'b1;
    bus.req = 12'hFFF;
    @(negedge clk);
    bus.load = 1'b0;
    bus.code_ready = 1'b1;
    o = snap();
    total++;
    if (o[10:9] !== 2'b11) begin
      $display("FAIL reset_preload got=%b exp=11", o[10:9]);
      bad++;
    end
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    o = snap();
    total++;
    if (o !== '0) begin
      $display("FAIL reset_async got=%h exp=%h", o, 11'h0);
      bad++;
    end
    @(negedge clk);
    bus.code_ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = snap();
      total++;
      if (o !== '0) begin
        $display("FAIL reset_release[%0d] got=%h exp=%h", i, o, 11'h0);
        bad++;
      end
    end
  endtask

  task automatic test_drain();
    logic [10:0] o;
    logic [11:0] r;
    logic [11:0] one;
    logic [3:0]  codes [3];
    logic [3:0]  cnts [3];
`ifdef PRIO_SCAN_ENC_LSB_FIRST_EN
    codes = '{4'd1, 4'd3, 4'd12};
`else
    codes = '{4'd12, 4'd3, 4'd1};
`endif
    cnts = '{4'd3, 4'd2, 4'd1};
    r = 12'b1000_0000_0101;
    one = 12'd1;
    bus.load = 1'b1;
    bus.req = r;
    bus.code_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
      bus.req = '0;
      o = snap();
      total++;
      if (o !== ex(1'b1, 1'b1, codes[i], cnts[i], 1'b0)) begin
        $display("FAIL drain[%0d] got=%h exp=%h", i, o,
                 ex(1'b1, 1'b1, codes[i], cnts[i], 1'b0));
        bad++;
      end
      total++;
      if (((one << (bus.code - 4'd1)) & r) == '0) begin
        $display("FAIL decode[%0d] code=%0d req=%h", i, bus.code, r);
        bad++;
      end
    end
    @(negedge clk);
    o = snap();
    total++;
    if (o !== ex(1'b0, 1'b0, 4'd0, 4'd0, 1'b1)) begin
      $display("FAIL drain_done got=%h exp=%h", o, ex(1'b0, 1'b0, 4'd0, 4'd0, 1'b1));
      bad++;
    end
    @(negedge clk);
    o = snap();
    total++;
    if (o !== '0) begin
      $display("FAIL drain_after got=%h exp=%h", o, 11'h0);
      bad++;
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] o;
    logic [3:0]  first;
    logic [3:0]  second;
`ifdef PRIO_SCAN_ENC_LSB_FIRST_EN
    first = 4'd7;
    second = 4'd8;
`else
    first = 4'd8;
    second = 4'd7;
`endif
    bus.load = 1'b1;
    bus.req = 12'h0C0;
    bus.code_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
      o = snap();
      total++;
      if (o !== ex(1'b1, 1'b1, first, 4'd2, 1'b0)) begin
        $display("FAIL stall[%0d] got=%h exp=%h", i, o,
                 ex(1'b1, 1'b1, first, 4'd2, 1'b0));
        bad++;
      end
    end
    bus.code_ready = 1'b1;
    @(negedge clk);
    o = snap();
    total++;
    if (o !== ex(1'b1, 1'b1, second, 4'd1, 1'b0)) begin
      $display("FAIL bp_second got=%h exp=%h", o, ex(1'b1, 1'b1, second, 4'd1, 1'b0));
      bad++;
    end
    @(negedge clk);
    o = snap();
    total++;
    if (o !== ex(1'b0, 1'b0, 4'd0, 4'd0, 1'b1)) begin
      $display("FAIL bp_done got=%h exp=%h", o, ex(1'b0, 1'b0, 4'd0, 4'd0, 1'b1));
      bad++;
    end
  endtask

  task automatic test_empty_load();
    logic [10:0] o;
    @(negedge clk);
    bus.load = 1'b1;
    bus.req = '0;
    @(negedge clk);
    bus.load = 1'b0;
    o = snap();
    total++;
    if (o !== ex(1'b0, 1'b0, 4'd0, 4'd0, 1'b1)) begin
      $display("FAIL empty_done got=%h exp=%h", o, ex(1'b0, 1'b0, 4'd0, 4'd0, 1'b1));
      bad++;
    end
    @(negedge clk);
    o = snap();
    total++;
    if (o !== '0) begin
      $display("FAIL empty_after got=%h exp=%h", o, 11'h0);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] o;
    int dones;
    bus.load = 1'b1;
    bus.req = 12'h001;
    bus.code_ready = 1'b0;
    @(negedge clk);
    // load while busy must be ignored
    bus.load = 1'b1;
    bus.req = 12'hFFF;
    @(negedge clk);
    o = snap();
    total++;
    if (o !== ex(1'b1, 1'b1, 4'd1, 4'd1, 1'b0)) begin
      $display("FAIL busy_load got=%h exp=%h", o, ex(1'b1, 1'b1, 4'd1, 4'd1, 1'b0));
      bad++;
    end
    // final handshake with a coincident load, which is also ignored
    bus.code_ready = 1'b1;
    @(negedge clk);
    o = snap();
    total++;
    if (o !== ex(1'b0, 1'b0, 4'd0, 4'd0, 1'b1)) begin
      $display("FAIL b2b_done got=%h exp=%h", o, ex(1'b0, 1'b0, 4'd0, 4'd0, 1'b1));
      bad++;
    end
    bus.req = 12'h800;
    @(negedge clk);
    bus.load = 1'b0;
    bus.req = '0;
    o = snap();
    total++;
    if (o !== ex(1'b1, 1'b1, 4'd12, 4'd1, 1'b0)) begin
      $display("FAIL b2b_next got=%h exp=%h", o, ex(1'b1, 1'b1, 4'd12, 4'd1, 1'b0));
      bad++;
    end
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
      total++;
      if (bus.busy !== 1'b0) begin
        $display("FAIL b2b_idle[%0d] busy got=%b exp=0", i, bus.busy);
        bad++;
      end
    end
    total++;
    if (dones != 1) begin
      $display("FAIL b2b_pulses got=%0d exp=1", dones);
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_backpressure();
    test_empty_load();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
